bus_mem_responder: RTL and testbench

- Word-wide memory slave that answers the pCPU memory bus (a/d/we/rd/spo/ready) from the responder side.
- Models a memory with a programmable number of wait states, so that the CPU's memory wait path can be exercised in simulation and on the FPGA.
- Backed by an internal word array. Sits behind the address decoder in place of, or alongside, the boot RAM.

---
 rtl/bus_mem_responder_if.sv | 15 +
 rtl/bus_mem_responder.sv | 142 ++++++++++++++
 tb/tb_bus_mem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bus_mem_responder_if.sv
// Memory bus bundle between a pCPU master and a memory responder.
// Handshake: the master pulses rd or we for exactly one cycle with a/d valid
// only in that cycle; the responder holds ready low until the access is done.
// When ready is high after a read, spo carries the read data.
interface bus_mem_responder_if;
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        ready;

  modport master (output a, d, we, rd, input spo, ready);
  modport slave  (input a, d, we, rd, output spo, ready);
endinterface

// File: rtl/bus_mem_responder.sv
// Word-wide memory slave for the pCPU bus with a programmable number of wait
// states. WAIT_CYCLES=0 gives a combinational, zero-wait response. Otherwise
// an IDLE/WAIT/DONE FSM holds ready low for WAIT_CYCLES cycles per access.
module bus_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  bus_mem_responder_if.slave  bus,
  output logic                proto_err,
  output logic [1:0]          dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic                  strobe;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_widx;
  logic [31:0]           mem_wdata;
  logic                  spo_ld;
  logic [ADDR_WIDTH-1:0] spo_idx;
  logic [31:0]           spo_q;
  logic                  perr_set;
  logic                  unused_addr_bits;

  assign cur_idx          = bus.a[ADDR_WIDTH+1:2];
  assign strobe           = bus.rd | bus.we;
  assign unused_addr_bits = ^{bus.a[31:ADDR_WIDTH+2], bus.a[1:0]};

  // Word array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  // Read data register, held until the next completed read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         spo_q <= '0;
    else if (spo_ld) spo_q <= mem[spo_idx];
  end

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           proto_err <= 1'b0;
    else if (perr_set) proto_err <= 1'b1;
  end

  generate
    if (WAIT_CYCLES == 0) begin : g_zero
      // Zero-wait path: access happens in the strobe cycle, no FSM.
      always_comb begin
        mem_we    = bus.we & ~rst;
        mem_widx  = cur_idx;
        mem_wdata = bus.d;
        spo_ld    = bus.rd & ~bus.we;
        spo_idx   = cur_idx;
        perr_set  = bus.rd & bus.we;
        bus.ready = 1'b1;
        bus.spo   = spo_ld ? mem[cur_idx] : spo_q;
        dbg_state = S_IDLE;
      end
    end else begin : g_wait
      localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

      state_t                state;
      state_t                state_n;
      logic [CW-1:0]         cnt;
      logic [ADDR_WIDTH-1:0] idx_q;
      logic [31:0]           data_q;
      logic                  we_q;
      logic                  accept;
      logic                  last;

      // A strobe is taken only outside WAIT; the op commits on the edge
      // where the counter steps from 1 to 0.
      assign accept = strobe & (state != S_WAIT);
      assign last   = (state == S_WAIT) && (cnt == CW'(1));

      // State register plus the latched request (index, data, op type).
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state  <= S_IDLE;
          cnt    <= '0;
          idx_q  <= '0;
          data_q <= '0;
          we_q   <= 1'b0;
        end else begin
          state <= state_n;
          if (accept) begin
            cnt    <= CW'(WAIT_CYCLES - 1);
            idx_q  <= cur_idx;
            data_q <= bus.d;
            we_q   <= bus.we;
          end else if (state == S_WAIT) begin
            cnt <= cnt - CW'(1);
          end
        end
      end

      // Next-state logic; with one wait state the FSM skips WAIT entirely.
      always_comb begin
        state_n = state;
        case (state)
          S_IDLE, S_DONE: begin
            if (accept) state_n = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
            else        state_n = S_IDLE;
          end
          S_WAIT:  if (last) state_n = S_DONE;
          default: state_n = S_IDLE;
        endcase
      end

      // Outputs and commit strobes; write wins over read when both pulse.
      always_comb begin
        mem_we    = 1'b0;
        mem_widx  = idx_q;
        mem_wdata = data_q;
        spo_ld    = 1'b0;
        spo_idx   = idx_q;
        perr_set  = (bus.rd & bus.we) | (strobe & (state == S_WAIT));
        bus.ready = (state == S_WAIT) ? 1'b0 : ~strobe;
        bus.spo   = spo_q;
        dbg_state = state;
        if ((WAIT_CYCLES == 1) && accept) begin
          mem_we    = bus.we & ~rst;
          mem_widx  = cur_idx;
          mem_wdata = bus.d;
          spo_ld    = ~bus.we;
          spo_idx   = cur_idx;
        end else if (last) begin
          mem_we    = we_q & ~rst;
          spo_ld    = ~we_q;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: four instances with 0, 1, 2 and 255 wait
// states, a word-array model and an expected-read queue.
module tb_bus_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_mem_responder_if if0 ();
  bus_mem_responder_if if1 ();
  bus_mem_responder_if if2 ();
  bus_mem_responder_if if3 ();

  logic       perr0, perr1, perr2, perr3;
  logic [1:0] st0, st1, st2, st3;

  bus_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0))   u0 (.clk(clk), .rst(rst), .bus(if0), .proto_err(perr0), .dbg_state(st0));
  bus_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1))   u1 (.clk(clk), .rst(rst), .bus(if1), .proto_err(perr1), .dbg_state(st1));
  bus_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2))   u2 (.clk(clk), .rst(rst), .bus(if2), .proto_err(perr2), .dbg_state(st2));
  bus_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(255)) u3 (.clk(clk), .rst(rst), .bus(if3), .proto_err(perr3), .dbg_state(st3));

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl[int];
  logic [31:0] last_spo[4];
  logic        exp_perr[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic rd);
    case (sel)
      0: begin if0.a = a; if0.d = d; if0.we = we; if0.rd = rd; end
      1: begin if1.a = a; if1.d = d; if1.we = we; if1.rd = rd; end
      2: begin if2.a = a; if2.d = d; if2.we = we; if2.rd = rd; end
      default: begin if3.a = a; if3.d = d; if3.we = we; if3.rd = rd; end
    endcase
  endtask

  task automatic sample(input int sel, output logic r, output logic [31:0] s, output logic p);
    case (sel)
      0: begin r = if0.ready; s = if0.spo; p = perr0; end
      1: begin r = if1.ready; s = if1.spo; p = perr1; end
      2: begin r = if2.ready; s = if2.spo; p = perr2; end
      default: begin r = if3.ready; s = if3.spo; p = perr3; end
    endcase
  endtask

  // Idle cycle: ready high, spo holding the last read result.
  task automatic idle(input int sel, input string tag);
    logic r; logic [31:0] s; logic p;
    @(negedge clk);
    set_in(sel, $urandom, $urandom, 1'b0, 1'b0);
    #1;
    sample(sel, r, s, p);
    check({tag, "_idle_rdy"}, 32'(r), 32'd1);
    check({tag, "_idle_spo"}, s, last_spo[sel]);
  endtask

  // One transaction with n wait states. b2b strobes in the current (DONE)
  // cycle; inject pulses rd in the first cycle after the strobe.
  task automatic xact(input int sel, input int n, input logic [31:0] a, input logic [31:0] d,
                      input logic we, input logic rd, input bit b2b, input bit inject,
                      input string tag);
    logic r; logic [31:0] s; logic p; logic [31:0] e;
    int key; int low;
    if (!b2b) @(negedge clk);
    set_in(sel, a, d, we, rd);
    #1;
    sample(sel, r, s, p);
    key = sel * 4096 + int'((a >> 2) & 32'h3ff);
    check({tag, "_rdy_strobe"}, 32'(r), (n == 0) ? 32'd1 : 32'd0);
    if (rd && !we) exp_q.push_back(mdl[key]);
    if (we) mdl[key] = d;
    if (we && rd) exp_perr[sel] = 1'b1;
    if (n == 0) begin
      if (rd && !we) begin
        e = exp_q.pop_front();
        check({tag, "_spo"}, s, e);
        last_spo[sel] = e;
      end
      idle(sel, tag);
    end else begin
      low = 1;
      @(negedge clk);
      set_in(sel, $urandom, $urandom, 1'b0, inject);
      if (inject) exp_perr[sel] = 1'b1;
      #1;
      sample(sel, r, s, p);
      while (r !== 1'b1 && low < 300) begin
        check({tag, "_spo_hold"}, s, last_spo[sel]);
        low++;
        @(negedge clk);
        set_in(sel, $urandom, $urandom, 1'b0, 1'b0);
        #1;
        sample(sel, r, s, p);
      end
      check({tag, "_low_cycles"}, 32'(low), 32'(n));
      if (rd && !we) begin
        e = exp_q.pop_front();
        check({tag, "_spo"}, s, e);
        last_spo[sel] = e;
      end
    end
    check({tag, "_perr"}, 32'(p), 32'(exp_perr[sel]));
  endtask

  initial begin
    logic r; logic [31:0] s; logic p;
    for (int i = 0; i < 4; i++) begin
      set_in(i, 32'h0, 32'h0, 1'b0, 1'b0);
      last_spo[i] = 32'h0;
      exp_perr[i] = 1'b0;
    end

    // Reset state, checked before any clock edge.
    #1;
    for (int i = 0; i < 4; i++) begin
      sample(i, r, s, p);
      check("reset_rdy", 32'(r), 32'd1);
      check("reset_spo", s, 32'h0);
      check("reset_perr", 32'(p), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Two wait states: write then read back.
    xact(2, 2, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, "w2_wr10");
    xact(2, 2, 32'h10, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, "w2_rd10");
    idle(2, "w2_hold1");
    idle(2, "w2_hold2");

    // Zero wait states, including the a[1:0] alias.
    xact(0, 0, 32'h4, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, "w0_wr4");
    xact(0, 0, 32'h4, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, "w0_rd4");
    xact(0, 0, 32'h7, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, "w0_rd7");

    // Back-to-back reads: second strobe in the DONE cycle of the first.
    xact(2, 2, 32'h14, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_wr14");
    xact(2, 2, 32'h18, 32'h22222222, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_wr18");
    xact(2, 2, 32'h14, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, "b2b_rd14");
    xact(2, 2, 32'h18, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, "b2b_rd18");

    // Violations: rd during WAIT, and rd&we together.
    xact(2, 2, 32'h30, 32'hCAFE0001, 1'b1, 1'b0, 1'b0, 1'b0, "v_wr30");
    xact(2, 2, 32'h30, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, "v_rd30_inj");
    xact(2, 2, 32'h10, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, "v_sticky");
    xact(1, 1, 32'h8,  32'h55,       1'b1, 1'b1, 1'b0, 1'b0, "v_rdwe8");
    xact(1, 1, 32'h8,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, "v_rd8");

    // One wait state and address wrap above ADDR_WIDTH.
    xact(1, 1, 32'h0,    32'h5A5A0000, 1'b1, 1'b0, 1'b0, 1'b0, "w1_wr0");
    xact(1, 1, 32'h1000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, "w1_rd1000");

    // Asynchronous reset in the middle of a pending write.
    xact(2, 2, 32'h20, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 1'b0, "rm_wr20");
    @(negedge clk);
    set_in(2, 32'h20, 32'hAAAA5555, 1'b1, 1'b0);
    @(negedge clk);
    set_in(2, $urandom, $urandom, 1'b0, 1'b0);
    #1;
    sample(2, r, s, p);
    check("rm_pre_rdy", 32'(r), 32'd0);
    #1 rst = 1'b1;
    #1;
    sample(2, r, s, p);
    check("rm_rdy", 32'(r), 32'd1);
    check("rm_spo", s, 32'h0);
    check("rm_perr", 32'(p), 32'd0);
    sample(1, r, s, p);
    check("rm_w1_spo", s, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      last_spo[i] = 32'h0;
      exp_perr[i] = 1'b0;
    end
    xact(2, 2, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, "rm_rd20");

    // 255 wait states.
    xact(3, 255, 32'h100, 32'h00000077, 1'b1, 1'b0, 1'b0, 1'b0, "w255_wr");
    xact(3, 255, 32'h100, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, "w255_rd");

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
